id_ex_stage: RTL and testbench
==============================

# id_ex_stage

ID/EX pipeline stage of the pipelined LEGv8 CPU. Registers the decoded instruction bundle from the decode stage and presents it to the execute stage, where the ALU-control decoder and ALU consume it. Includes load-use hazard detection with single-bubble insertion, honours a branch flush and a downstream hold, and keeps a saturating bubble counter for performance debug.

## Interface
- `WIDTH`, default 64: datapath width of register operands and immediate.
- `CNT_W`, default 16: width of the bubble counter.

Ports:
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `id_valid` input 1: decode stage holds a real instruction.
- `id_alu_op0`, `id_alu_op1` input 1 each: ALUOp bits from main control.
- `id_alu_src`, `id_mem_read`, `id_mem_write`, `id_reg_write`, `id_mem_to_reg`, `id_branch` input 1 each: main-control bits.
- `id_opcode` input 11: instruction[31:21].
- `id_rd1`, `id_rd2` input WIDTH: register-file read data.
- `id_imm` input WIDTH: sign-extended immediate.
- `id_rn`, `id_rm`, `id_rd` input 5: register indices.
- `id_uses_rm` input 1: the instruction reads Rm (R-format).
- `flush` input 1: branch taken; kill the instruction entering EX.
- `ex_hold` input 1: downstream cannot accept; freeze EX contents.
- `id_stall` output 1: combinational; IF/ID must hold its contents this cycle.
- `ex_valid` output 1, plus `ex_alu_op0`, `ex_alu_op1`, `ex_alu_src`, `ex_mem_read`, `ex_mem_write`, `ex_reg_write`, `ex_mem_to_reg`, `ex_branch` output 1 each: registered copies.
- `ex_opcode` output 11, `ex_rd1`/`ex_rd2`/`ex_imm` output WIDTH, `ex_rn`/`ex_rm`/`ex_rd` output 5: registered copies.
- `bubble_count` output CNT_W: number of load-use bubbles inserted.

## Operation
- Hazard: `ex_valid & ex_mem_read & id_valid & (ex_rd != 31) & ((ex_rd == id_rn) | (id_uses_rm & (ex_rd == id_rm)))`.
- Per-edge action, in priority order:
  - `flush`: load a bubble.
  - `ex_hold`: keep all EX registers unchanged.
  - hazard: load a bubble and increment the counter.
  - otherwise: load the ID bundle with `ex_valid = id_valid`.
- Bubble: `ex_valid` and all eight control bits are 0. Opcode, data and indices are don't-care and are cleared to 0. With ALUOp = 00, the downstream ALU control selects ADD (harmless).
- `id_stall = !flush & (ex_hold | hazard)`.
- `bubble_count` increments by 1 per inserted load-use bubble and saturates at all-ones. It does not wrap.
- Register 31 (XZR) never produces a hazard.

## Timing
- Latency: 1 cycle, ID inputs to `ex_*` outputs.
- `id_stall` is combinational from the current EX registers and the ID inputs. It is valid in the same cycle.
- A load-use hazard produces exactly one bubble:
  - the cycle after insertion, EX holds the bubble, so the hazard term is 0;
  - the held ID instruction then advances.
- If `ex_hold` and hazard are both true: hold wins, no bubble is inserted, the counter does not change, and `id_stall = 1`.
- If `flush` and hazard are both true: flush wins, no counter increment, and `id_stall = 0` (upstream is flushed too).
- If `flush` and `ex_hold` are both true: EX is cleared.
- Reset, asserted at any time (including mid-stall), immediately forces:
  - all `ex_*` outputs to 0;
  - `bubble_count` to 0;
  - `id_stall` to 0, since `ex_valid = 0`.
- On the first edge after `rst_n` rises, normal loading resumes.

## Structure
- Shared package `legv8_pkg`:
  - opcode constants ADD `10001011000`, SUB `11001011000`, AND `10001010000`, ORR `10101010000`, LDUR, STUR, CBZ, B;
  - `XZR = 5'd31`;
  - ALUOp encodings (00 memory, 01 branch, 10 R-type);
  - a packed control-bundle type shared by ID, EX, MEM and WB registers.
- Sub-module `load_use_detect`: combinational comparator producing `hazard`. It is reused later by the stall logic for ID/EX forwarding.
- Top level: the register bank, the priority mux and the saturating counter.

## Test plan
- Reset then pass-through:
  - stimulus: ADD (`id_opcode = 10001011000`, `alu_op = 10`, rd1 = 5, rd2 = 7, `id_valid = 1`);
  - response: one cycle later `ex_valid = 1`, `ex_opcode` and `ex_rd1`/`ex_rd2` match, `id_stall = 0`.
- Load-use on Rn:
  - stimulus: LDUR X3 in EX, ID holds ADD with rn = 3;
  - response: `id_stall = 1` for one cycle, EX gets a bubble (all control 0), `bubble_count = 1`, then the ADD enters EX.
- XZR and Rm gating:
  - stimulus A: LDUR to X31 with ID rn = 31;
  - stimulus B: LDUR X4 with ID rm = 4 and `id_uses_rm = 0`;
  - response: no stall and no bubble in either case.
- Priority:
  - stimulus: hazard plus `flush` in the same cycle;
  - response: bubble loaded, `id_stall = 0`, counter unchanged.
  - stimulus: hazard plus `ex_hold`;
  - response: EX unchanged, `id_stall = 1`, counter unchanged.
- Saturation and reset:
  - stimulus: force `bubble_count` to 0xFFFE, then create 3 hazards;
  - response: count reads 0xFFFF.
  - stimulus: assert `rst_n = 0` mid-stall;
  - response: all outputs read 0 immediately.

Source files
------------

// File: rtl/legv8_pkg.sv
// Shared LEGv8 pipeline definitions: opcodes, register constants, ALUOp
// encodings and the control bundle carried through the pipeline registers.
package legv8_pkg;

    // Opcodes as instruction[31:21]; short-opcode formats are padded with zeros.
    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_SUB  = 11'b11001011000;
    localparam logic [10:0] OP_AND  = 11'b10001010000;
    localparam logic [10:0] OP_ORR  = 11'b10101010000;
    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;
    localparam logic [10:0] OP_CBZ  = 11'b10110100000;
    localparam logic [10:0] OP_B    = 11'b00010100000;

    // Zero register: reads as zero, so it never carries a load result.
    localparam logic [4:0] XZR = 5'd31;

    // ALUOp encodings from main control.
    typedef enum logic [1:0] {
        ALUOP_MEM    = 2'b00,
        ALUOP_BRANCH = 2'b01,
        ALUOP_RTYPE  = 2'b10
    } alu_op_e;

    // Control bundle shared by ID/EX, EX/MEM and MEM/WB registers.
    typedef struct packed {
        logic [1:0] alu_op;     // {ALUOp1, ALUOp0}
        logic       alu_src;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic       mem_to_reg;
        logic       branch;
    } ctrl_t;

    // What the ID/EX register does on the next edge.
    typedef enum logic [1:0] {
        ACT_LOAD   = 2'd0,
        ACT_HOLD   = 2'd1,
        ACT_BUBBLE = 2'd2
    } ex_action_e;

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard comparator: a load in EX whose destination is read by the
// instruction in ID. XZR never forms a dependency.
module load_use_detect
    import legv8_pkg::*;
(
    input  logic       i_ex_valid,
    input  logic       i_ex_mem_read,
    input  logic [4:0] i_ex_rd,
    input  logic       i_id_valid,
    input  logic [4:0] i_id_rn,
    input  logic [4:0] i_id_rm,
    input  logic       i_id_uses_rm,
    output logic       o_hazard
);

    logic w_rn_match;
    logic w_rm_match;

    assign w_rn_match = (i_ex_rd == i_id_rn);
    assign w_rm_match = i_id_uses_rm & (i_ex_rd == i_id_rm);

    assign o_hazard = i_ex_valid & i_ex_mem_read & i_id_valid
                    & (i_ex_rd != XZR) & (w_rn_match | w_rm_match);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, branch flush,
// downstream hold and a saturating bubble counter for performance debug.
module id_ex_stage
    import legv8_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic             id_alu_op0,
    input  logic             id_alu_op1,
    input  logic             id_alu_src,
    input  logic             id_mem_read,
    input  logic             id_mem_write,
    input  logic             id_reg_write,
    input  logic             id_mem_to_reg,
    input  logic             id_branch,
    input  logic [10:0]      id_opcode,
    input  logic [WIDTH-1:0] id_rd1,
    input  logic [WIDTH-1:0] id_rd2,
    input  logic [WIDTH-1:0] id_imm,
    input  logic [4:0]       id_rn,
    input  logic [4:0]       id_rm,
    input  logic [4:0]       id_rd,
    input  logic             id_uses_rm,
    input  logic             flush,
    input  logic             ex_hold,
    output logic             id_stall,
    output logic             ex_valid,
    output logic             ex_alu_op0,
    output logic             ex_alu_op1,
    output logic             ex_alu_src,
    output logic             ex_mem_read,
    output logic             ex_mem_write,
    output logic             ex_reg_write,
    output logic             ex_mem_to_reg,
    output logic             ex_branch,
    output logic [10:0]      ex_opcode,
    output logic [WIDTH-1:0] ex_rd1,
    output logic [WIDTH-1:0] ex_rd2,
    output logic [WIDTH-1:0] ex_imm,
    output logic [4:0]       ex_rn,
    output logic [4:0]       ex_rm,
    output logic [4:0]       ex_rd,
    output logic [CNT_W-1:0] bubble_count
);

    ctrl_t            w_id_ctrl;
    logic             w_hazard;
    logic             w_count_inc;
    ex_action_e       w_action;

    logic             r_valid;
    ctrl_t            r_ctrl;
    logic [10:0]      r_opcode;
    logic [WIDTH-1:0] r_rd1;
    logic [WIDTH-1:0] r_rd2;
    logic [WIDTH-1:0] r_imm;
    logic [4:0]       r_rn;
    logic [4:0]       r_rm;
    logic [4:0]       r_rd;
    logic [CNT_W-1:0] r_bubble_count;

    assign w_id_ctrl = '{
        alu_op:     {id_alu_op1, id_alu_op0},
        alu_src:    id_alu_src,
        mem_read:   id_mem_read,
        mem_write:  id_mem_write,
        reg_write:  id_reg_write,
        mem_to_reg: id_mem_to_reg,
        branch:     id_branch
    };

    load_use_detect u_load_use_detect (
        .i_ex_valid    (r_valid),
        .i_ex_mem_read (r_ctrl.mem_read),
        .i_ex_rd       (r_rd),
        .i_id_valid    (id_valid),
        .i_id_rn       (id_rn),
        .i_id_rm       (id_rm),
        .i_id_uses_rm  (id_uses_rm),
        .o_hazard      (w_hazard)
    );

    // Priority select: flush, then hold, then load-use bubble, then load.
    // NOTE: assigning a default first keeps this block free of inferred latches.
    always_comb begin
        w_action = ACT_LOAD;
        if (flush) begin
            w_action = ACT_BUBBLE;
        end else if (ex_hold) begin
            w_action = ACT_HOLD;
        end else if (w_hazard) begin
            w_action = ACT_BUBBLE;
        end
    end

    // Only a bubble caused by the hazard itself is counted, not a flush.
    assign w_count_inc = !flush & !ex_hold & w_hazard;

    // A flushed ID instruction is discarded, so upstream must not hold for it.
    assign id_stall = !flush & (ex_hold | w_hazard);

    // ID/EX register bank; bubbles clear every field so EX sees an ADD of zeros.
    // NOTE: non-blocking assignments let every register sample pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid  <= 1'b0;
            r_ctrl   <= '0;
            r_opcode <= '0;
            r_rd1    <= '0;
            r_rd2    <= '0;
            r_imm    <= '0;
            r_rn     <= '0;
            r_rm     <= '0;
            r_rd     <= '0;
        end else begin
            case (w_action)
                ACT_LOAD: begin
                    r_valid  <= id_valid;
                    r_ctrl   <= w_id_ctrl;
                    r_opcode <= id_opcode;
                    r_rd1    <= id_rd1;
                    r_rd2    <= id_rd2;
                    r_imm    <= id_imm;
                    r_rn     <= id_rn;
                    r_rm     <= id_rm;
                    r_rd     <= id_rd;
                end
                ACT_BUBBLE: begin
                    r_valid  <= 1'b0;
                    r_ctrl   <= '0;
                    r_opcode <= '0;
                    r_rd1    <= '0;
                    r_rd2    <= '0;
                    r_imm    <= '0;
                    r_rn     <= '0;
                    r_rm     <= '0;
                    r_rd     <= '0;
                end
                default: begin
                    // ACT_HOLD: registers keep their contents.
                end
            endcase
        end
    end

    // Saturating count of load-use bubbles; sticks at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bubble_count <= '0;
        end else if (w_count_inc && (r_bubble_count != '1)) begin
            r_bubble_count <= r_bubble_count + 1'b1;
        end
    end

    assign ex_valid      = r_valid;
    assign ex_alu_op1    = r_ctrl.alu_op[1];
    assign ex_alu_op0    = r_ctrl.alu_op[0];
    assign ex_alu_src    = r_ctrl.alu_src;
    assign ex_mem_read   = r_ctrl.mem_read;
    assign ex_mem_write  = r_ctrl.mem_write;
    assign ex_reg_write  = r_ctrl.reg_write;
    assign ex_mem_to_reg = r_ctrl.mem_to_reg;
    assign ex_branch     = r_ctrl.branch;
    assign ex_opcode     = r_opcode;
    assign ex_rd1        = r_rd1;
    assign ex_rd2        = r_rd2;
    assign ex_imm        = r_imm;
    assign ex_rn         = r_rn;
    assign ex_rm         = r_rm;
    assign ex_rd         = r_rd;
    assign bubble_count  = r_bubble_count;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed, table-driven bench for id_ex_stage. A second instance with a
// 2-bit counter shares the stimulus to exercise counter saturation.
module tb_id_ex_stage;
    import legv8_pkg::*;

    localparam int W = 64;
    localparam logic [7:0] C_ADD = 8'h84;   // ALUOp 10, reg_write
    localparam logic [7:0] C_LD  = 8'h36;   // ALUOp 00, alu_src, mem_read, reg_write, mem_to_reg

    typedef enum logic [1:0] {K_LOAD, K_HOLD, K_BUB} kind_e;

    typedef struct {
        logic          v;
        logic [7:0]    c;
        logic [10:0]   op;
        logic [4:0]    rn, rm, rd;
        logic          um;
        logic [W-1:0]  d1, d2, imm;
        logic          fl, ho;
        logic          exp_stall;
        kind_e         kind;
        int            exp_cnt;
        int            exp_sat;
    } vec_t;

    typedef struct {
        logic          v;
        logic [7:0]    c;
        logic [10:0]   op;
        logic [W-1:0]  d1, d2, imm;
        logic [4:0]    rn, rm, rd;
    } ex_t;

    logic clk = 1'b0;
    logic rst_n;
    logic id_valid, id_alu_op0, id_alu_op1, id_alu_src, id_mem_read, id_mem_write;
    logic id_reg_write, id_mem_to_reg, id_branch, id_uses_rm, flush, ex_hold;
    logic [10:0]  id_opcode;
    logic [W-1:0] id_rd1, id_rd2, id_imm;
    logic [4:0]   id_rn, id_rm, id_rd;

    logic id_stall, ex_valid, ex_alu_op0, ex_alu_op1, ex_alu_src, ex_mem_read;
    logic ex_mem_write, ex_reg_write, ex_mem_to_reg, ex_branch;
    logic [10:0]  ex_opcode;
    logic [W-1:0] ex_rd1, ex_rd2, ex_imm;
    logic [4:0]   ex_rn, ex_rm, ex_rd;
    logic [15:0]  bubble_count;

    logic s_stall, s_valid, s_op0, s_op1, s_src, s_mr, s_mw, s_rw, s_m2r, s_br;
    logic [10:0]  s_opcode;
    logic [W-1:0] s_rd1, s_rd2, s_imm;
    logic [4:0]   s_rn, s_rm, s_rd;
    logic [1:0]   s_count;

    int checks = 0;
    int errors = 0;
    ex_t model;
    vec_t tbl[23];

    always #5 clk = ~clk;

    id_ex_stage #(.WIDTH(W), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
        .id_alu_op0(id_alu_op0), .id_alu_op1(id_alu_op1), .id_alu_src(id_alu_src),
        .id_mem_read(id_mem_read), .id_mem_write(id_mem_write), .id_reg_write(id_reg_write),
        .id_mem_to_reg(id_mem_to_reg), .id_branch(id_branch), .id_opcode(id_opcode),
        .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm),
        .id_rn(id_rn), .id_rm(id_rm), .id_rd(id_rd), .id_uses_rm(id_uses_rm),
        .flush(flush), .ex_hold(ex_hold), .id_stall(id_stall), .ex_valid(ex_valid),
        .ex_alu_op0(ex_alu_op0), .ex_alu_op1(ex_alu_op1), .ex_alu_src(ex_alu_src),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_reg_write(ex_reg_write),
        .ex_mem_to_reg(ex_mem_to_reg), .ex_branch(ex_branch), .ex_opcode(ex_opcode),
        .ex_rd1(ex_rd1), .ex_rd2(ex_rd2), .ex_imm(ex_imm),
        .ex_rn(ex_rn), .ex_rm(ex_rm), .ex_rd(ex_rd), .bubble_count(bubble_count)
    );

    id_ex_stage #(.WIDTH(W), .CNT_W(2)) u_sat (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
        .id_alu_op0(id_alu_op0), .id_alu_op1(id_alu_op1), .id_alu_src(id_alu_src),
        .id_mem_read(id_mem_read), .id_mem_write(id_mem_write), .id_reg_write(id_reg_write),
        .id_mem_to_reg(id_mem_to_reg), .id_branch(id_branch), .id_opcode(id_opcode),
        .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm),
        .id_rn(id_rn), .id_rm(id_rm), .id_rd(id_rd), .id_uses_rm(id_uses_rm),
        .flush(flush), .ex_hold(ex_hold), .id_stall(s_stall), .ex_valid(s_valid),
        .ex_alu_op0(s_op0), .ex_alu_op1(s_op1), .ex_alu_src(s_src),
        .ex_mem_read(s_mr), .ex_mem_write(s_mw), .ex_reg_write(s_rw),
        .ex_mem_to_reg(s_m2r), .ex_branch(s_br), .ex_opcode(s_opcode),
        .ex_rd1(s_rd1), .ex_rd2(s_rd2), .ex_imm(s_imm),
        .ex_rn(s_rn), .ex_rm(s_rm), .ex_rd(s_rd), .bubble_count(s_count)
    );

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic v, input logic [7:0] c, input logic [10:0] op,
                                input logic [4:0] rn, input logic [4:0] rm, input logic [4:0] rd,
                                input logic um, input logic [W-1:0] d1,
                                input logic fl, input logic ho, input logic st,
                                input kind_e k, input int cnt, input int sat);
        vec_t t;
        t.v = v; t.c = c; t.op = op; t.rn = rn; t.rm = rm; t.rd = rd; t.um = um;
        t.d1 = d1; t.d2 = d1 + 64'd2; t.imm = d1 ^ 64'hFFFF_0000_0000_FF00;
        t.fl = fl; t.ho = ho; t.exp_stall = st; t.kind = k;
        t.exp_cnt = cnt; t.exp_sat = sat;
        return t;
    endfunction

    task automatic drive(input vec_t t);
        id_valid = t.v;
        {id_alu_op1, id_alu_op0, id_alu_src, id_mem_read,
         id_mem_write, id_reg_write, id_mem_to_reg, id_branch} = t.c;
        id_opcode = t.op; id_rd1 = t.d1; id_rd2 = t.d2; id_imm = t.imm;
        id_rn = t.rn; id_rm = t.rm; id_rd = t.rd; id_uses_rm = t.um;
        flush = t.fl; ex_hold = t.ho;
    endtask

    function automatic logic [7:0] ex_ctrl();
        return {ex_alu_op1, ex_alu_op0, ex_alu_src, ex_mem_read,
                ex_mem_write, ex_reg_write, ex_mem_to_reg, ex_branch};
    endfunction

    task automatic compare_ex(input string tag);
        check({tag, " ex_valid"},  W'(ex_valid),  W'(model.v));
        check({tag, " ex_ctrl"},   W'(ex_ctrl()), W'(model.c));
        check({tag, " ex_opcode"}, W'(ex_opcode), W'(model.op));
        check({tag, " ex_rd1"},    ex_rd1,        model.d1);
        check({tag, " ex_rd2"},    ex_rd2,        model.d2);
        check({tag, " ex_imm"},    ex_imm,        model.imm);
        check({tag, " ex_rn"},     W'(ex_rn),     W'(model.rn));
        check({tag, " ex_rm"},     W'(ex_rm),     W'(model.rm));
        check({tag, " ex_rd"},     W'(ex_rd),     W'(model.rd));
    endtask

    task automatic step(input int idx, input vec_t t);
        string tag;
        tag = $sformatf("v%0d", idx);
        @(negedge clk);
        drive(t);
        #1;
        check({tag, " id_stall"}, W'(id_stall), W'(t.exp_stall));
        check({tag, " sat id_stall"}, W'(s_stall), W'(t.exp_stall));
        case (t.kind)
            K_LOAD: model = '{v: t.v, c: t.c, op: t.op, d1: t.d1, d2: t.d2,
                              imm: t.imm, rn: t.rn, rm: t.rm, rd: t.rd};
            K_BUB:  model = '{v: 1'b0, c: '0, op: '0, d1: '0, d2: '0,
                              imm: '0, rn: '0, rm: '0, rd: '0};
            default: ;
        endcase
        @(posedge clk);
        #1;
        compare_ex(tag);
        check({tag, " bubble_count"}, W'(bubble_count), W'(t.exp_cnt));
        check({tag, " sat bubble_count"}, W'(s_count), W'(t.exp_sat));
    endtask

    initial begin
        vec_t t;
        // Sequence: pass-through, Rn hazard, XZR, Rm gating, Rm hazard,
        // flush priority, hold priority, flush+hold, invalid ID, saturation.
        tbl[0]  = mk(1, C_ADD, OP_ADD,  1, 2,  9, 1,   5, 0, 0, 0, K_LOAD, 0, 0);
        tbl[1]  = mk(1, C_LD,  OP_LDUR, 1, 0,  3, 0, 100, 0, 0, 0, K_LOAD, 0, 0);
        tbl[2]  = mk(1, C_ADD, OP_ADD,  3, 5,  6, 1,  11, 0, 0, 1, K_BUB,  1, 1);
        tbl[3]  = mk(1, C_ADD, OP_ADD,  3, 5,  6, 1,  11, 0, 0, 0, K_LOAD, 1, 1);
        tbl[4]  = mk(1, C_LD,  OP_LDUR, 2, 0, 31, 0,  50, 0, 0, 0, K_LOAD, 1, 1);
        tbl[5]  = mk(1, C_ADD, OP_ADD, 31, 1,  7, 1,   3, 0, 0, 0, K_LOAD, 1, 1);
        tbl[6]  = mk(1, C_LD,  OP_LDUR, 1, 0,  4, 0,  60, 0, 0, 0, K_LOAD, 1, 1);
        tbl[7]  = mk(1, C_ADD, OP_ADD,  2, 4,  8, 0,   4, 0, 0, 0, K_LOAD, 1, 1);
        tbl[8]  = mk(1, C_LD,  OP_LDUR, 1, 0,  5, 0,  70, 0, 0, 0, K_LOAD, 1, 1);
        tbl[9]  = mk(1, C_ADD, OP_ADD,  1, 5, 10, 1,   1, 0, 0, 1, K_BUB,  2, 2);
        tbl[10] = mk(1, C_ADD, OP_ADD,  1, 5, 10, 1,   1, 0, 0, 0, K_LOAD, 2, 2);
        tbl[11] = mk(1, C_LD,  OP_LDUR, 1, 0,  6, 0,  80, 0, 0, 0, K_LOAD, 2, 2);
        tbl[12] = mk(1, C_ADD, OP_ADD,  6, 1, 11, 1,  12, 1, 0, 0, K_BUB,  2, 2);
        tbl[13] = mk(1, C_LD,  OP_LDUR, 1, 0,  7, 0,  90, 0, 0, 0, K_LOAD, 2, 2);
        tbl[14] = mk(1, C_ADD, OP_ADD,  7, 1, 12, 1,  13, 0, 1, 1, K_HOLD, 2, 2);
        tbl[15] = mk(1, C_ADD, OP_ADD,  7, 1, 12, 1,  13, 0, 0, 1, K_BUB,  3, 3);
        tbl[16] = mk(1, C_ADD, OP_ADD,  7, 1, 12, 1,  13, 0, 0, 0, K_LOAD, 3, 3);
        tbl[17] = mk(1, C_ADD, OP_ADD,  1, 1, 13, 1,  14, 1, 1, 0, K_BUB,  3, 3);
        tbl[18] = mk(1, C_LD,  OP_LDUR, 1, 0,  2, 0,  95, 0, 0, 0, K_LOAD, 3, 3);
        tbl[19] = mk(0, C_ADD, OP_ADD,  2, 2, 14, 1,  15, 0, 0, 0, K_LOAD, 3, 3);
        tbl[20] = mk(1, C_LD,  OP_LDUR, 1, 0,  2, 0,  96, 0, 0, 0, K_LOAD, 3, 3);
        tbl[21] = mk(1, C_ADD, OP_ADD,  2, 3, 15, 1,  16, 0, 0, 1, K_BUB,  4, 3);
        tbl[22] = mk(1, C_ADD, OP_ADD,  2, 3, 15, 1,  16, 0, 0, 0, K_LOAD, 4, 3);

        // Reset state.
        rst_n = 1'b0;
        drive(mk(0, 8'h00, 11'd0, 0, 0, 0, 0, 0, 0, 0, 0, K_BUB, 0, 0));
        model = '{v: 1'b0, c: '0, op: '0, d1: '0, d2: '0, imm: '0, rn: '0, rm: '0, rd: '0};
        repeat (2) @(posedge clk);
        #1;
        compare_ex("reset");
        check("reset id_stall", W'(id_stall), '0);
        check("reset bubble_count", W'(bubble_count), '0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 23; i++) begin
            step(i, tbl[i]);
        end

        // Reset asserted mid-stall clears everything without waiting for an edge.
        step(23, mk(1, C_LD, OP_LDUR, 1, 0, 9, 0, 200, 0, 0, 0, K_LOAD, 4, 3));
        @(negedge clk);
        t = mk(1, C_ADD, OP_ADD, 9, 1, 17, 1, 21, 0, 0, 0, K_LOAD, 0, 0);
        drive(t);
        #1;
        check("midstall id_stall before reset", W'(id_stall), W'(1'b1));
        #1;
        rst_n = 1'b0;
        #1;
        model = '{v: 1'b0, c: '0, op: '0, d1: '0, d2: '0, imm: '0, rn: '0, rm: '0, rd: '0};
        compare_ex("midstall reset");
        check("midstall reset id_stall", W'(id_stall), '0);
        check("midstall reset bubble_count", W'(bubble_count), '0);
        check("midstall reset sat bubble_count", W'(s_count), '0);

        // First edge after release loads the waiting ADD normally.
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post reset id_stall", W'(id_stall), '0);
        model = '{v: t.v, c: t.c, op: t.op, d1: t.d1, d2: t.d2,
                  imm: t.imm, rn: t.rn, rm: t.rm, rd: t.rd};
        @(posedge clk);
        #1;
        compare_ex("post reset");
        check("post reset bubble_count", W'(bubble_count), '0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
